sid_table_sched: RTL

Parametrised scheduler that shares one registered combined-waveform table ROM (`sid_tables`-style, four 8-bit outputs) among `NUM_VOICES` oscillators. Sits between the voice instances and the shared table in single- or multi-SID tops. On each `ce_1m` it snapshots every voice's accumulator lookup addresses and streams them to the ROM at one voice per clock. It commits all looked-up results atomically, so downstream voices never see a mixed old/new set.

---
 rtl/sid_table_sched_if.sv | 34 +++
 rtl/sid_table_sched.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/sid_table_sched_if.sv
// -----------------------------------------------------------------------------
// sid_table_sched_if
//
// Bus between the table scheduler and the shared combined-waveform table ROM.
// The scheduler presents two registered 12-bit lookup addresses. The ROM
// returns four 8-bit table values a fixed number of clocks later.
//
//   rom_acc_ps  12  pulse/saw lookup address   (scheduler -> ROM)
//   rom_acc_t   12  triangle lookup address    (scheduler -> ROM)
//   rom_st       8  saw+triangle table data    (ROM -> scheduler)
//   rom_pt       8  pulse+triangle table data  (ROM -> scheduler)
//   rom_ps       8  pulse+saw table data       (ROM -> scheduler)
//   rom_pst      8  pulse+saw+tri table data   (ROM -> scheduler)
//
// master: the scheduler side. slave: the ROM side.
// -----------------------------------------------------------------------------
interface sid_table_sched_if;
    logic [11:0] rom_acc_ps;
    logic [11:0] rom_acc_t;
    logic [7:0]  rom_st;
    logic [7:0]  rom_pt;
    logic [7:0]  rom_ps;
    logic [7:0]  rom_pst;

    modport master (
        output rom_acc_ps, rom_acc_t,
        input  rom_st, rom_pt, rom_ps, rom_pst
    );

    modport slave (
        input  rom_acc_ps, rom_acc_t,
        output rom_st, rom_pt, rom_ps, rom_pst
    );
endinterface

// File: rtl/sid_table_sched.sv
// -----------------------------------------------------------------------------
// sid_table_sched
//
// Time-shares one registered combined-waveform table ROM among NUM_VOICES
// oscillators. On each ce_1m it snapshots all voice lookup addresses and
// issues them to the ROM at one voice per clock. Returning data is collected
// in shadow registers. Once the last voice has returned, all results are
// committed to the outputs on a single edge, so consumers never see a mixed
// old/new set.
//
// Parameters
//   NUM_VOICES  voices served per sample (1..8)
//   ROM_LAT     clocks from ROM address update to valid ROM data (1..4)
//
// Ports
//   clk          system clock
//   reset        asynchronous, active-high reset
//   ce_1m        one-clock sample strobe; starts (or restarts) a sequence
//   acc_ps       pulse/saw lookup addresses, voice k on [12k+11:12k]
//   acc_t        triangle lookup addresses, same packing
//   rom          ROM bus (master side): registered addresses out, data in
//   st_out       committed saw+tri results, voice k on [8k+7:8k]
//   pt_out       committed pulse+tri results, same packing
//   ps_out       committed pulse+saw results, same packing
//   pst_out      committed pulse+saw+tri results, same packing
//   busy         a sequence is in progress
//   done         one-clock pulse after a commit
//   overrun      sticky: a sequence was aborted by an early ce_1m
//   overrun_clr  clears overrun (a simultaneous set wins)
// -----------------------------------------------------------------------------
module sid_table_sched #(
    parameter int NUM_VOICES = 3,
    parameter int ROM_LAT    = 2
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      ce_1m,
    input  logic [12*NUM_VOICES-1:0]  acc_ps,
    input  logic [12*NUM_VOICES-1:0]  acc_t,
    sid_table_sched_if.master         rom,
    output logic [8*NUM_VOICES-1:0]   st_out,
    output logic [8*NUM_VOICES-1:0]   pt_out,
    output logic [8*NUM_VOICES-1:0]   ps_out,
    output logic [8*NUM_VOICES-1:0]   pst_out,
    output logic                      busy,
    output logic                      done,
    output logic                      overrun,
    input  logic                      overrun_clr
);

    localparam int IDX_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VOICES - 1);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN,
        COMMIT
    } state_t;

    state_t           state;
    logic [IDX_W-1:0] idx;

    // Per-voice address snapshot taken on the strobe.
    logic [11:0] snap_ps [NUM_VOICES];
    logic [11:0] snap_t  [NUM_VOICES];

    // Per-voice results collected as ROM data returns; copied out on commit.
    logic [7:0]  sh_st   [NUM_VOICES];
    logic [7:0]  sh_pt   [NUM_VOICES];
    logic [7:0]  sh_ps   [NUM_VOICES];
    logic [7:0]  sh_pst  [NUM_VOICES];

    // Valid/index pipe that tracks which voice's data is arriving from the
    // ROM. The head stage is valid exactly at the edge where that voice's
    // data may be sampled.
    logic             pipe_v   [ROM_LAT];
    logic [IDX_W-1:0] pipe_idx [ROM_LAT];

    logic             head_v;
    logic [IDX_W-1:0] head_idx;

    assign head_v   = pipe_v[ROM_LAT-1];
    assign head_idx = pipe_idx[ROM_LAT-1];

    // NOTE: all state below is written with non-blocking assignments, so every
    // register sees pre-edge values and statement order only matters where a
    // later assignment deliberately overrides an earlier one on the same edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            idx            <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            overrun        <= 1'b0;
            rom.rom_acc_ps <= '0;
            rom.rom_acc_t  <= '0;
            st_out         <= '0;
            pt_out         <= '0;
            ps_out         <= '0;
            pst_out        <= '0;
            // NOTE: the snapshot and shadow arrays are plain registers, not RAM,
            // so they can be reset. This makes the post-reset state fully defined.
            for (int k = 0; k < NUM_VOICES; k++) begin
                snap_ps[k] <= '0;
                snap_t[k]  <= '0;
                sh_st[k]   <= '0;
                sh_pt[k]   <= '0;
                sh_ps[k]   <= '0;
                sh_pst[k]  <= '0;
            end
            for (int i = 0; i < ROM_LAT; i++) begin
                pipe_v[i]   <= 1'b0;
                pipe_idx[i] <= '0;
            end
        end else begin
            done <= 1'b0;

            // Advance the return-tracking pipe. Stage 0 is refilled below
            // only while issuing.
            for (int i = ROM_LAT - 1; i > 0; i--) begin
                pipe_v[i]   <= pipe_v[i-1];
                pipe_idx[i] <= pipe_idx[i-1];
            end
            pipe_v[0] <= 1'b0;

            // Capture returning ROM data for the voice at the pipe head.
            if (head_v) begin
                sh_st[head_idx]  <= rom.rom_st;
                sh_pt[head_idx]  <= rom.rom_pt;
                sh_ps[head_idx]  <= rom.rom_ps;
                sh_pst[head_idx] <= rom.rom_pst;
            end

            case (state)
                IDLE: begin
                    // Addresses hold their last value while idle.
                end

                ISSUE: begin
                    if (!ce_1m) begin
                        rom.rom_acc_ps <= snap_ps[idx];
                        rom.rom_acc_t  <= snap_t[idx];
                        pipe_v[0]      <= 1'b1;
                        pipe_idx[0]    <= idx;
                        if (idx == LAST_IDX) begin
                            state <= DRAIN;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                end

                DRAIN: begin
                    // The last voice is issued last, so its capture ends the drain.
                    if (!ce_1m && head_v && head_idx == LAST_IDX) begin
                        state <= COMMIT;
                    end
                end

                COMMIT: begin
                    for (int k = 0; k < NUM_VOICES; k++) begin
                        st_out[8*k +: 8]  <= sh_st[k];
                        pt_out[8*k +: 8]  <= sh_pt[k];
                        ps_out[8*k +: 8]  <= sh_ps[k];
                        pst_out[8*k +: 8] <= sh_pst[k];
                    end
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end

                default: state <= IDLE;
            endcase

            if (overrun_clr) begin
                overrun <= 1'b0;
            end

            // A strobe always (re)starts a sequence from voice 0. Arriving
            // mid-sequence, it also aborts the one in flight. Arriving on the
            // commit edge, the commit above still happens and busy stays set.
            if (ce_1m) begin
                if (state == ISSUE || state == DRAIN) begin
                    overrun <= 1'b1;
                    for (int i = 0; i < ROM_LAT; i++) begin
                        pipe_v[i] <= 1'b0;
                    end
                    for (int k = 0; k < NUM_VOICES; k++) begin
                        sh_st[k]  <= '0;
                        sh_pt[k]  <= '0;
                        sh_ps[k]  <= '0;
                        sh_pst[k] <= '0;
                    end
                end
                for (int k = 0; k < NUM_VOICES; k++) begin
                    snap_ps[k] <= acc_ps[12*k +: 12];
                    snap_t[k]  <= acc_t[12*k +: 12];
                end
                idx   <= '0;
                busy  <= 1'b1;
                state <= ISSUE;
            end
        end
    end

endmodule
